// File: rtl/tone_bank.sv
// -----------------------------------------------------------------------------
// tone_bank
//
// Multi-channel programmable square-wave tone generator. Every channel divides
// the system clock by a run-time loadable half-period and produces a 50% duty
// square wave. A divider written through the shared write port is held as
// "pending" and is only applied at the channel's next toggle boundary, so a
// half-period is never cut short by a divider change. A single-cycle sync
// pulse restarts every channel low and in phase.
//
// Parameters:
//   NUM_CH  number of tone channels (1..16)
//   DIV_W   divider / counter width; max half-period is 2^DIV_W-1 cycles
//   CH_W    width of the channel index
//
// Ports:
//   clk       system clock, all state changes on the rising edge
//   reset     asynchronous active-high reset
//   load      divider write strobe (one write per cycle)
//   load_ch   channel targeted by the write; indices >= NUM_CH are ignored
//   load_div  new half-period in clk cycles; 0 silences the channel
//   sync      single-cycle pulse restarting all channels in phase
//   ch_en     per-channel output enable (gates the output only)
//   out       tone outputs, out[i] = tone[i] & ch_en[i]
//   pending   pending[i] is 1 while a written divider awaits application
// -----------------------------------------------------------------------------
module tone_bank #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 24,
  parameter int CH_W   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [CH_W-1:0]   load_ch,
  input  logic [DIV_W-1:0]  load_div,
  input  logic              sync,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] out,
  output logic [NUM_CH-1:0] pending
);

  localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [NUM_CH-1:0] toneVec_s;
  logic [NUM_CH-1:0] pendVec_s;

  for (genvar g = 0; g < NUM_CH; g++) begin : gCh
    logic [DIV_W-1:0] activeDiv_r;
    logic [DIV_W-1:0] pendDiv_r;
    logic [DIV_W-1:0] counter_r;
    logic             tone_r;
    logic             pendV_r;

    logic [DIV_W-1:0] activeDiv_s;
    logic [DIV_W-1:0] pendDiv_s;
    logic [DIV_W-1:0] counter_s;
    logic             tone_s;
    logic             pendV_s;

    logic             hit_s;
    logic             effV_s;
    logic [DIV_W-1:0] effDiv_s;

    // A same-cycle write bypasses the stored pending value so that a write
    // landing exactly on a boundary (or on sync) is applied at that edge.
    assign hit_s    = load & (32'(load_ch) == 32'(g));
    assign effV_s   = hit_s ? 1'b1 : pendV_r;
    assign effDiv_s = hit_s ? load_div : pendDiv_r;

    // Next-state logic for one channel: sync, then silent, then boundary,
    // then plain counting.
    always_comb begin
      activeDiv_s = activeDiv_r;
      pendDiv_s   = pendDiv_r;
      counter_s   = counter_r;
      tone_s      = tone_r;
      pendV_s     = pendV_r;

      if (sync) begin
        counter_s = DIV_ZERO;
        tone_s    = 1'b0;
        if (effV_s) begin
          activeDiv_s = effDiv_s;
          pendV_s     = 1'b0;
        end else begin
          pendV_s     = 1'b0;
        end
      end else if (activeDiv_r == DIV_ZERO) begin
        // Silent: nothing to wait for, a pending divider starts right away.
        counter_s = DIV_ZERO;
        tone_s    = 1'b0;
        if (effV_s) begin
          activeDiv_s = effDiv_s;
          pendV_s     = 1'b0;
        end else begin
          pendV_s     = 1'b0;
        end
      end else if (counter_r == (activeDiv_r - DIV_ONE)) begin
        counter_s = DIV_ZERO;
        if (effV_s) begin
          activeDiv_s = effDiv_s;
          pendV_s     = 1'b0;
          // Switching to silence parks the output low instead of toggling.
          tone_s      = (effDiv_s == DIV_ZERO) ? 1'b0 : ~tone_r;
        end else begin
          tone_s      = ~tone_r;
        end
      end else begin
        counter_s = counter_r + DIV_ONE;
        if (hit_s) begin
          pendDiv_s = load_div;
          pendV_s   = 1'b1;
        end else begin
          pendV_s   = pendV_r;
        end
      end
    end

    // Channel state registers.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        activeDiv_r <= DIV_ZERO;
        pendDiv_r   <= DIV_ZERO;
        counter_r   <= DIV_ZERO;
        tone_r      <= 1'b0;
        pendV_r     <= 1'b0;
      end else begin
        activeDiv_r <= activeDiv_s;
        pendDiv_r   <= pendDiv_s;
        counter_r   <= counter_s;
        tone_r      <= tone_s;
        pendV_r     <= pendV_s;
      end
    end

    assign toneVec_s[g] = tone_r;
    assign pendVec_s[g] = pendV_r;
  end

  // Enables only mask the outputs; counters keep running for phase continuity.
  assign out     = toneVec_s & ch_en;
  assign pending = pendVec_s;

endmodule

// File: tb/tb_tone_bank.sv
// Scoreboard bench for tone_bank (NUM_CH=3, DIV_W=8, CH_W=2). The stimulus
// process pushes the hand-computed {out,pending} expected after each clock
// edge; the monitor pops and compares on the following falling edge.
module tb_tone_bank;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic [1:0] load_ch = 2'd0;
  logic [7:0] load_div = 8'd0;
  logic       sync = 1'b0;
  logic [2:0] ch_en = 3'b111;
  logic [2:0] out;
  logic [2:0] pending;

  int nVec = 0;
  int nMis = 0;

  string      nmQ[$];
  logic [5:0] expQ[$];

  tone_bank #(.NUM_CH(3), .DIV_W(8), .CH_W(2)) dut (
    .clk(clk), .reset(reset), .load(load), .load_ch(load_ch),
    .load_div(load_div), .sync(sync), .ch_en(ch_en),
    .out(out), .pending(pending)
  );

  always #5 clk = ~clk;

  // Monitor: compare one queued expectation per falling edge.
  initial begin
    string      n;
    logic [5:0] e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        n = nmQ.pop_front();
        nVec++;
        if ({out, pending} !== e) begin
          nMis++;
          $display("FAIL %s: out=%b pending=%b, expected out=%b pending=%b",
                   n, out, pending, e[5:3], e[2:0]);
        end
      end
    end
  end

  // One clock edge; queue the expected state after it.
  task automatic cyc(input string nm, input logic [2:0] eo, input logic [2:0] ep);
    @(posedge clk);
    #1;
    nmQ.push_back(nm);
    expQ.push_back({eo, ep});
  endtask

  // Reset pulse placed entirely inside a clock low phase.
  task automatic resetPulse();
    @(negedge clk);
    #1 reset = 1'b1;
    #2 reset = 1'b0;
  endtask

  logic [18:0] t1Out  = 19'b0011100011100000000;  // ch0, edges E0+1..E0+19
  logic [18:0] t1Pend = 19'b0000000000001100000;
  logic [16:0] t2Out  = 17'b00000111110011001;    // ch1, edges F0..F0+16
  logic [16:0] t2Pend = 17'b00000001110000000;
  logic [2:0]  t4Pre [10] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b001,
                              3'b001, 3'b001, 3'b011, 3'b010, 3'b010};
  logic [2:0]  t4Post [13] = '{3'b000, 3'b000, 3'b100, 3'b100, 3'b001,
                               3'b001, 3'b111, 3'b111, 3'b010, 3'b010,
                               3'b110, 3'b110, 3'b001};
  logic [20:0] t6Out  = 21'b000110000000000111000; // ch0 gated, edges H0..H0+20

  initial begin
    // Reset state.
    cyc("reset_state", 3'b000, 3'b000);
    reset = 1'b0;

    // ch0 div=3 from silence, then div=0 written while the tone is low.
    load = 1'b1; load_ch = 2'd0; load_div = 8'd3;
    cyc("ch0_load3", 3'b000, 3'b000);
    load = 1'b0;
    for (int k = 1; k <= 19; k++) begin
      if (k == 13) begin
        load = 1'b1; load_ch = 2'd0; load_div = 8'd0;
      end
      cyc("ch0_div3_then_0", {2'b00, t1Out[19-k]}, {2'b00, t1Pend[19-k]});
      load = 1'b0;
    end

    // ch1 div=5, div=2 written two edges after the rising boundary.
    for (int k = 0; k <= 16; k++) begin
      if (k == 0) begin
        load = 1'b1; load_ch = 2'd1; load_div = 8'd5;
      end else if (k == 7) begin
        load = 1'b1; load_ch = 2'd1; load_div = 8'd2;
      end
      cyc("ch1_5_to_2", {1'b0, t2Out[16-k], 1'b0}, {1'b0, t2Pend[16-k], 1'b0});
      load = 1'b0;
    end

    // Mid-run reset with no clock edge while asserted.
    resetPulse();
    cyc("reset_midrun", 3'b000, 3'b000);

    // Out-of-range channel write must not touch anything.
    load = 1'b1; load_ch = 2'd3; load_div = 8'd7;
    cyc("bad_ch_write", 3'b000, 3'b000);
    load = 1'b0;
    for (int k = 1; k <= 8; k++) cyc("bad_ch_idle", 3'b000, 3'b000);

    // ch0 div=4, ch1 div=6 free-running, then sync with a ch2 div=2 write.
    for (int k = 0; k <= 9; k++) begin
      if (k == 0) begin
        load = 1'b1; load_ch = 2'd0; load_div = 8'd4;
      end else if (k == 1) begin
        load = 1'b1; load_ch = 2'd1; load_div = 8'd6;
      end
      cyc("sync_pre", t4Pre[k], 3'b000);
      load = 1'b0;
    end
    sync = 1'b1; load = 1'b1; load_ch = 2'd2; load_div = 8'd2;
    cyc("sync_edge", t4Post[0], 3'b000);
    sync = 1'b0; load = 1'b0;
    for (int k = 1; k <= 12; k++) cyc("sync_post", t4Post[k], 3'b000);

    // Reset clears running channels, then ch0 div=3 with a 7-cycle enable gap.
    resetPulse();
    cyc("reset_midrun2", 3'b000, 3'b000);
    for (int k = 0; k <= 20; k++) begin
      if (k == 0) begin
        load = 1'b1; load_ch = 2'd0; load_div = 8'd3;
      end
      cyc("ch0_en_gap", {2'b00, t6Out[20-k]}, 3'b000);
      load = 1'b0;
      ch_en[0] = (k < 5 || k > 11);
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && expQ.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (expQ.size() > 0) begin
      nMis++;
      $display("FAIL drain: %0d entries left, expected 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
